// File: rtl/alu_result_capture_pkg.sv
// Shared definitions for the ALU result capture stage: command encodings and FIFO entry layout.
package alu_result_capture_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    typedef struct packed {
        logic [2:0]           command;
        logic [ALU_WIDTH-1:0] result;
        logic                 carryout;
        logic                 zero;
        logic                 overflow;
    } alu_entry_t;

    localparam int ENTRY_W = $bits(alu_entry_t);

    // Only add/subtract produce meaningful carry and overflow flags.
    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd == ALU_ADD) || (cmd == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// In-order FIFO: storage, wrapping pointers and occupancy counter; output is a mux of storage.
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wptr, rptr;
    logic [CW-1:0]               count;
    logic                        do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_capture.sv
// Captures ALU results into a FIFO, masking non-arithmetic flags and tracking overflow events.
module alu_result_capture
    import alu_result_capture_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_command,
    input  logic [ALU_WIDTH-1:0] in_result,
    input  logic                 in_carryout,
    input  logic                 in_zero,
    input  logic                 in_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_command,
    output logic [ALU_WIDTH-1:0] out_result,
    output logic                 out_carryout,
    output logic                 out_zero,
    output logic                 out_overflow,
    input  logic                 clear_sticky,
    output logic                 sticky_overflow,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    alu_entry_t wentry, rentry;
    logic       full, empty, push, pop, ovf_push, arith;

    assign arith           = is_arith(in_command);
    assign wentry.command  = in_command;
    assign wentry.result   = in_result;
    assign wentry.carryout = arith & in_carryout;
    assign wentry.zero     = in_zero;
    assign wentry.overflow = arith & in_overflow;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ovf_push  = push && wentry.overflow;

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .full  (full),
        .empty (empty)
    );

    assign out_command  = rentry.command;
    assign out_result   = rentry.result;
    assign out_carryout = rentry.carryout;
    assign out_zero     = rentry.zero;
    assign out_overflow = rentry.overflow;

    // A same-cycle overflow push beats clear_sticky so the event is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_overflow <= 1'b0;
            ovf_count       <= '0;
        end else if (clear_sticky) begin
            sticky_overflow <= ovf_push;
            ovf_count       <= ovf_push ? OVF_CNT_W'(1) : '0;
        end else if (ovf_push) begin
            sticky_overflow <= 1'b1;
            if (ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule
